// File: rtl/nco_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nco_sweep_ctrl
// Description : Stepped-frequency sweep controller driving an NCO frequency
//               control word, with dwell timing, looping and abort.
//               Optional macro SWEEP_BIDIR_EN: sweep returns to the start FCW.
// Revision    : 1.0 - initial release
// ============================================================================
module nco_sweep_ctrl #(
  parameter int NCO_FREQ_BITS = 4,
  parameter int DWELL_BITS    = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start_in,
  input  logic                     stop_in,
  input  logic                     loop_in,
  input  logic [NCO_FREQ_BITS-1:0] fcw_start_in,
  input  logic [NCO_FREQ_BITS-1:0] fcw_stop_in,
  input  logic [DWELL_BITS-1:0]    dwell_in,
  output logic [NCO_FREQ_BITS-1:0] fcw_out,
  output logic                     phase_rst_out,
  output logic                     busy_out,
  output logic                     done_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [DWELL_BITS-1:0] c_dwell_one = {{(DWELL_BITS-1){1'b0}}, 1'b1};

  state_t                   state_q, state_d;
  logic [NCO_FREQ_BITS-1:0] fcw_q, fcw_d;
  logic                     phase_rst_q, phase_rst_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [DWELL_BITS-1:0]    cnt_q, cnt_d;
  logic                     loop_q, loop_d;
  logic [NCO_FREQ_BITS-1:0] fcw_start_q, fcw_start_d;
  logic [NCO_FREQ_BITS-1:0] fcw_stop_q, fcw_stop_d;
  logic [DWELL_BITS-1:0]    dwell_q, dwell_d;
  logic                     dir_up_q, dir_up_d;
  logic [NCO_FREQ_BITS-1:0] w_target;
  logic [NCO_FREQ_BITS-1:0] w_step;
`ifdef SWEEP_BIDIR_EN
  logic                     rev_q, rev_d;
`endif

  always_comb begin
    state_d     = state_q;
    fcw_d       = fcw_q;
    phase_rst_d = 1'b0;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    loop_d      = loop_q;
    fcw_start_d = fcw_start_q;
    fcw_stop_d  = fcw_stop_q;
    dwell_d     = dwell_q;
    dir_up_d    = dir_up_q;
`ifdef SWEEP_BIDIR_EN
    rev_d       = rev_q;
    // On the return leg the sweep terminates at the start FCW.
    w_target    = rev_q ? fcw_start_q : fcw_stop_q;
`else
    w_target    = fcw_stop_q;
`endif
    w_step      = dir_up_q ? fcw_q + 1'b1 : fcw_q - 1'b1;

    case (state_q)
      ST_IDLE: begin
        fcw_d = '0;
        if (start_in && !stop_in) begin
          fcw_start_d = fcw_start_in;
          fcw_stop_d  = fcw_stop_in;
          dwell_d     = (dwell_in == '0) ? c_dwell_one : dwell_in;
          loop_d      = loop_in;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        fcw_d       = fcw_start_q;
        phase_rst_d = 1'b1;
        cnt_d       = dwell_q - 1'b1;
        dir_up_d    = (fcw_stop_q >= fcw_start_q);
`ifdef SWEEP_BIDIR_EN
        rev_d       = 1'b0;
`endif
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (fcw_q == w_target) begin
`ifdef SWEEP_BIDIR_EN
          if (!rev_q && (fcw_start_q != fcw_stop_q)) begin
            // Turn around immediately so the end FCW is held only once.
            rev_d    = 1'b1;
            dir_up_d = !dir_up_q;
            fcw_d    = dir_up_q ? fcw_q - 1'b1 : fcw_q + 1'b1;
            cnt_d    = dwell_q - 1'b1;
          end else begin
            fcw_d   = '0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
`else
          fcw_d   = '0;
          done_d  = 1'b1;
          state_d = ST_DONE;
`endif
        end else begin
          fcw_d = w_step;
          cnt_d = dwell_q - 1'b1;
        end
      end
      ST_DONE: begin
        fcw_d   = '0;
        state_d = loop_q ? ST_LOAD : ST_IDLE;
      end
      default: begin
        fcw_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides start, completion and looping.
    if (stop_in && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      fcw_d       = '0;
      phase_rst_d = 1'b0;
      done_d      = 1'b0;
      cnt_d       = '0;
      loop_d      = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      fcw_q       <= '0;
      phase_rst_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      loop_q      <= 1'b0;
      fcw_start_q <= '0;
      fcw_stop_q  <= '0;
      dwell_q     <= c_dwell_one;
      dir_up_q    <= 1'b1;
`ifdef SWEEP_BIDIR_EN
      rev_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      fcw_q       <= fcw_d;
      phase_rst_q <= phase_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      loop_q      <= loop_d;
      fcw_start_q <= fcw_start_d;
      fcw_stop_q  <= fcw_stop_d;
      dwell_q     <= dwell_d;
      dir_up_q    <= dir_up_d;
`ifdef SWEEP_BIDIR_EN
      rev_q       <= rev_d;
`endif
    end
  end

  assign fcw_out       = fcw_q;
  assign phase_rst_out = phase_rst_q;
  assign busy_out      = busy_q;
  assign done_out      = done_q;

endmodule
`default_nettype wire

// File: doc/nco_sweep_ctrl.md
NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 SHALL have parameter NCO_FREQ_BITS, default 4, width of the frequency control word driven to the NCO.
REQ-002 SHALL have parameter DWELL_BITS, default 16, width of the dwell-length input and the internal dwell counter.
REQ-003 SHALL have port clk_in  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start_in  input  1  request to start a sweep; sampled only in IDLE.
REQ-006 SHALL have port stop_in  input  1  abort request; sampled in every state.
REQ-007 SHALL have port loop_in  input  1  when 1, restart the sweep automatically after completion; latched at start.
REQ-008 SHALL have port fcw_start_in  input  NCO_FREQ_BITS  first FCW of the sweep; latched at start.
REQ-009 SHALL have port fcw_stop_in  input  NCO_FREQ_BITS  last FCW of the sweep; latched at start.
REQ-010 SHALL have port dwell_in  input  DWELL_BITS  cycles each FCW is held; latched at start; 0 is treated as 1.
REQ-011 SHALL have port fcw_out  output  NCO_FREQ_BITS  registered FCW, connects to the NCO fcw_in.
REQ-012 SHALL have port phase_rst_out  output  1  one-cycle pulse requesting an NCO phase-accumulator clear.
REQ-013 SHALL have port busy_out  output  1  high in every state except IDLE.
REQ-014 SHALL have port done_out  output  1  one-cycle pulse on normal sweep completion.

Function
REQ-015 SHALL implement states IDLE, LOAD, RUN, DONE; all outputs registered.
REQ-016 IDLE: fcw_out=0; on start_in=1 with stop_in=0, latch fcw_start/fcw_stop/dwell/loop and go LOAD; start_in in any other state is ignored.
REQ-017 LOAD (one cycle): at exit edge fcw_out<=latched start, phase_rst_out=1 for that one following cycle, dwell counter<=dwell-1, direction<=up if stop>=start else down; go RUN.
REQ-018 RUN: decrement counter each cycle; at counter=0, if fcw_out equals end target go DONE, else fcw_out steps by +/-1 per direction and counter reloads dwell-1, so every FCW is held exactly dwell cycles.
REQ-019 fcw_out SHALL be valid 2 edges after the edge sampling start_in; no FCW skipped, no wrap-around (step arithmetic never crosses the start/stop range).
REQ-020 fcw_start_in equal to fcw_stop_in SHALL produce one dwell period at that value, then DONE.
REQ-021 DONE (one cycle): done_out=1, fcw_out<=0; go LOAD if latched loop=1 (new phase_rst_out pulse), else IDLE.
REQ-022 stop_in=1 in LOAD, RUN or DONE SHALL force IDLE at the next edge with fcw_out=0, no done_out pulse, loop cleared; stop wins over start and completion in the same cycle.
REQ-023 Input changes after start SHALL NOT affect a running sweep.

Reset
REQ-024 rst_in=1 SHALL, at the next edge, force IDLE, fcw_out=0, phase_rst_out=0, busy_out=0, done_out=0, counter=0, loop=0, overriding all other inputs including mid-sweep.

Configuration
REQ-025 Macro SWEEP_BIDIR_EN defined: after fcw_stop's dwell, direction reverses and the sweep returns to fcw_start (fcw_stop held once, fcw_start held again at end), then DONE.
REQ-026 Macro SWEEP_BIDIR_EN undefined: sweep is one-directional and completes after fcw_stop's dwell; no reverse logic compiled in.

Verification
REQ-027 start=2, stop=5, dwell=3, loop=0 -> phase_rst_out one pulse; fcw_out 2,2,2,3,3,3,4,4,4,5,5,5; done_out one pulse; fcw_out=0, busy_out=0.
REQ-028 start=9, stop=7, dwell=0 -> fcw_out 9,8,7, one cycle each; done_out pulse; IDLE.
REQ-029 start=3, stop=3, dwell=4, loop=1 -> 3 held 4 cycles, done_out pulse, phase_rst_out pulse, repeats until stop_in=1 -> IDLE next edge, no further done_out.
REQ-030 stop_in and rst_in asserted separately mid-RUN (start=0, stop=15, dwell=2) -> next edge fcw_out=0, busy_out=0, done_out=0; start_in held during busy ignored.
REQ-031 SWEEP_BIDIR_EN defined, start=1, stop=3, dwell=1 -> fcw_out 1,2,3,2,1 then done_out pulse.
